mf8_regfile_p: RTL and testbench
================================

// Module: mf8_regfile_p
// PURPOSE
//  Parametrised dual-read/single-write register file for the mf8 core family.
//  Adds 16-bit pair (word) writes, high-byte read port, a reset-time clear
//  sequencer and optional X/Y pointer outputs alongside the Z pointer. Sits
//  between decode (addresses) and ALU (operands/result) in the execute stage.
// PARAMETERS
//  DATA_W          8   register width in bits
//  ADDR_W          5   address width; depth = 2**ADDR_W (min 3)
//  CLEAR_ON_RESET  1   1: zero every register after reset via sequencer; 0: contents undefined
// PORTS
//  Clk        in   1         rising-edge clock
//  Reset      in   1         asynchronous, active-low reset
//  Wr         in   1         write enable; target = Rd_Addr from previous cycle (Wr_Addr_r)
//  Wr_Word    in   1         with Wr: write pair {Wr_Addr_r|1, Wr_Addr_r&~1}
//  Rd_Addr    in   ADDR_W    destination/first-operand address
//  Rr_Addr    in   ADDR_W    second-operand address
//  Data_In    in   DATA_W    write data (low byte for word writes)
//  Data_In_H  in   DATA_W    high byte for word writes; ignored otherwise
//  Rd_Data    out  DATA_W    registered read of Rd_Addr
//  Rd_Data_H  out  DATA_W    registered read of Rd_Addr|1
//  Rr_Data    out  DATA_W    registered read of Rr_Addr
//  Z          out  2*DATA_W  {reg[TOP], reg[TOP-1]}, TOP = 2**ADDR_W-1
//  Busy       out  1         clear sequencer active; core must stall
// BEHAVIOUR
//  - Reset low (async): Wr_Addr_r=0, Rd_Data=Rd_Data_H=Rr_Data=0, Z=0, clear counter=0,
//    state=CLEAR and Busy=1 if CLEAR_ON_RESET else state=RUN and Busy=0. Array not reset.
//  - FSM CLEAR: each cycle write 0 to reg[cnt]; cnt++; at cnt==2**ADDR_W-1 write, go RUN,
//    Busy falls on same edge. Takes exactly 2**ADDR_W cycles after Reset release.
//    In CLEAR: Wr ignored, read outputs held 0, Wr_Addr_r still tracks Rd_Addr.
//  - FSM RUN: terminal; only Reset re-enters CLEAR. Reset mid-clear restarts at cnt=0.
//  - Every edge: Wr_Addr_r <= Rd_Addr.
//  - Byte write (Wr=1, Wr_Word=0): reg[Wr_Addr_r] <= Data_In.
//  - Word write (Wr=1, Wr_Word=1): LSB of Wr_Addr_r forced 0; reg[even] <= Data_In,
//    reg[even+1] <= Data_In_H, same edge.
//  - Reads: 1-cycle latency, all three ports every edge in RUN.
//  - Write-through bypass: any read port whose address equals a register written on
//    the same edge returns the new value (covers both bytes of a word write).
//  - Z: updated on the same edge as any write (byte or word) to TOP-1 / TOP; each byte
//    independently. Z reset 0; CLEAR sequencer also writes Z to 0.
//  - Rd_Addr|1 wraps naturally within ADDR_W; no out-of-range addresses exist.
// CONFIGURATION
//  MF8_REGFILE_XY_PTR_EN defined: extra outputs X = {reg[TOP-4],reg[TOP-5]} and
//    Y = {reg[TOP-2],reg[TOP-3]}, width 2*DATA_W, same update/reset/clear rules as Z.
//  Not defined: X and Y ports absent; no shadow registers for them.
// TESTING
//  1 Reset low, release, defaults -> Busy=1 for 32 cycles, then 0; all reads return 0x00.
//  2 Rd_Addr=3 cycle n, Wr=1 Data_In=0xA5 cycle n+1 -> Rd_Addr=3 cycle n+2: Rd_Data=0xA5.
//  3 Bypass: write 0x5C to r7 while Rr_Addr=7 same cycle -> Rr_Data=0x5C next cycle.
//  4 Word write Wr_Addr_r=29 (odd), Data_In=0x34 Data_In_H=0x12 -> r28=0x34, r29=0x12;
//    read Rd_Addr=28 -> Rd_Data=0x34, Rd_Data_H=0x12.
//  5 Word write to r30 0xEF/0xBE -> Z=0xBEEF same edge; byte write r31=0x00 -> Z=0x00EF.
//  6 Reset asserted at cnt=10 during clear -> outputs 0 immediately; clear restarts,
//    Busy held 32 cycles after release; Wr=1 during Busy leaves contents 0.

Source files
------------

// File: rtl/mf8_regfile_p_if.sv
// Bus bundle between the mf8 execute stage and its register file.
// MF8_REGFILE_XY_PTR_EN adds the X/Y pointer outputs.
interface mf8_regfile_p_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic                  wr;
    logic                  wr_word;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     rr_addr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W-1:0]     data_in_h;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     rd_data_h;
    logic [DATA_W-1:0]     rr_data;
    logic [2*DATA_W-1:0]   z;
    logic                  busy;
`ifdef MF8_REGFILE_XY_PTR_EN
    logic [2*DATA_W-1:0]   x;
    logic [2*DATA_W-1:0]   y;
`endif

    modport master (
        output wr, wr_word, rd_addr, rr_addr, data_in, data_in_h,
        input  rd_data, rd_data_h, rr_data, z, busy
`ifdef MF8_REGFILE_XY_PTR_EN
        , input x, y
`endif
    );

    modport slave (
        input  wr, wr_word, rd_addr, rr_addr, data_in, data_in_h,
        output rd_data, rd_data_h, rr_data, z, busy
`ifdef MF8_REGFILE_XY_PTR_EN
        , output x, y
`endif
    );
endinterface

// File: rtl/mf8_regfile_p.sv
// mf8 register file: 2 read ports + high-byte port, byte/word write, clear-after-reset sequencer.
// Define MF8_REGFILE_XY_PTR_EN to add X/Y pointer shadows next to Z.
module mf8_regfile_p #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 5,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic              i_clk,
    input logic              i_rst_n,
    mf8_regfile_p_if.slave   bus
);
    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] TOP    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] TOP_M1 = ADDR_W'(DEPTH - 2);

    typedef enum logic {StClear, StRun} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_next;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_data, r_rd_data_h, r_rr_data;
    logic [2*DATA_W-1:0] r_z;

    logic                w_we_lo, w_we_hi;
    logic [ADDR_W-1:0]   w_addr_lo, w_addr_hi;
    logic [DATA_W-1:0]   w_data_lo, w_data_hi;

    // New contents of a register on this edge, honouring same-edge writes.
    function automatic logic [DATA_W-1:0] f_upd(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] cur);
        if (w_we_hi && a == w_addr_hi) return w_data_hi;
        if (w_we_lo && a == w_addr_lo) return w_data_lo;
        return cur;
    endfunction

    // Write port decode; the sequencer owns the low-byte port during clear.
    always_comb begin
        w_we_lo   = 1'b0;
        w_we_hi   = 1'b0;
        w_addr_lo = r_wr_addr;
        w_addr_hi = r_wr_addr | ADDR_W'(1);
        w_data_lo = bus.data_in;
        w_data_hi = bus.data_in_h;
        if (r_state == StClear) begin
            w_we_lo   = 1'b1;
            w_addr_lo = r_cnt;
            w_data_lo = '0;
        end else if (bus.wr) begin
            w_we_lo = 1'b1;
            if (bus.wr_word) begin
                w_addr_lo = {r_wr_addr[ADDR_W-1:1], 1'b0};
                w_we_hi   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we_lo) r_mem[w_addr_lo] <= w_data_lo;
        if (w_we_hi) r_mem[w_addr_hi] <= w_data_hi;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= CLEAR_ON_RESET ? StClear : StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == StClear) begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == TOP) w_state_next = StRun;
        end
    end

    always_comb begin
        bus.busy = (r_state == StClear);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_addr   <= '0;
            r_rd_data   <= '0;
            r_rd_data_h <= '0;
            r_rr_data   <= '0;
            r_z         <= '0;
        end else begin
            r_wr_addr <= bus.rd_addr;
            r_z       <= {f_upd(TOP, r_z[2*DATA_W-1:DATA_W]), f_upd(TOP_M1, r_z[DATA_W-1:0])};
            if (r_state == StClear) begin
                r_rd_data   <= '0;
                r_rd_data_h <= '0;
                r_rr_data   <= '0;
            end else begin
                r_rd_data   <= f_upd(bus.rd_addr, r_mem[bus.rd_addr]);
                r_rd_data_h <= f_upd(bus.rd_addr | ADDR_W'(1), r_mem[bus.rd_addr | ADDR_W'(1)]);
                r_rr_data   <= f_upd(bus.rr_addr, r_mem[bus.rr_addr]);
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_data_h = r_rd_data_h;
    assign bus.rr_data   = r_rr_data;
    assign bus.z         = r_z;

`ifdef MF8_REGFILE_XY_PTR_EN
    localparam logic [ADDR_W-1:0] TOP_M2 = ADDR_W'(DEPTH - 3);
    localparam logic [ADDR_W-1:0] TOP_M3 = ADDR_W'(DEPTH - 4);
    localparam logic [ADDR_W-1:0] TOP_M4 = ADDR_W'(DEPTH - 5);
    localparam logic [ADDR_W-1:0] TOP_M5 = ADDR_W'(DEPTH - 6);

    logic [2*DATA_W-1:0] r_x, r_y;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= {f_upd(TOP_M4, r_x[2*DATA_W-1:DATA_W]), f_upd(TOP_M5, r_x[DATA_W-1:0])};
            r_y <= {f_upd(TOP_M2, r_y[2*DATA_W-1:DATA_W]), f_upd(TOP_M3, r_y[DATA_W-1:0])};
        end
    end

    assign bus.x = r_x;
    assign bus.y = r_y;
`endif
endmodule

// File: tb/tb_mf8_regfile_p.sv
// Directed self-checking bench for mf8_regfile_p (default 8x32 build).
module tb_mf8_regfile_p;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    mf8_regfile_p_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    mf8_regfile_p #(.DATA_W(8), .ADDR_W(5), .CLEAR_ON_RESET(1'b1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.wr = 1'b0;
        bus.wr_word = 1'b0;
        bus.rd_addr = '0;
        bus.rr_addr = '0;
        bus.data_in = '0;
        bus.data_in_h = '0;

        // Reset and first clear sequence
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_rd", 32'(bus.rd_data), 32'h00);
        check("rst_z", 32'(bus.z), 32'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("clr_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        check("clr_done", 32'(bus.busy), 32'd0);

        bus.rd_addr = 5'd5;
        bus.rr_addr = 5'd9;
        tick();
        check("zero_rd", 32'(bus.rd_data), 32'h00);
        check("zero_rdh", 32'(bus.rd_data_h), 32'h00);
        check("zero_rr", 32'(bus.rr_data), 32'h00);

        // Byte write to r3 through the delayed write address
        bus.rd_addr = 5'd3;
        tick();
        bus.wr = 1'b1;
        bus.data_in = 8'hA5;
        tick();
        bus.wr = 1'b0;
        check("byp_rd_r3", 32'(bus.rd_data), 32'hA5);
        tick();
        check("rd_r3", 32'(bus.rd_data), 32'hA5);
        check("rdh_r3", 32'(bus.rd_data_h), 32'hA5);

        // Bypass on the Rr port
        bus.rd_addr = 5'd7;
        tick();
        bus.wr = 1'b1;
        bus.data_in = 8'h5C;
        bus.rr_addr = 5'd7;
        bus.rd_addr = 5'd0;
        tick();
        bus.wr = 1'b0;
        check("byp_rr_r7", 32'(bus.rr_data), 32'h5C);
        check("rd_r0", 32'(bus.rd_data), 32'h00);

        // Word write with odd address 29 lands on r28/r29
        bus.rd_addr = 5'd29;
        tick();
        bus.wr = 1'b1;
        bus.wr_word = 1'b1;
        bus.data_in = 8'h34;
        bus.data_in_h = 8'h12;
        bus.rd_addr = 5'd28;
        bus.rr_addr = 5'd29;
        tick();
        bus.wr = 1'b0;
        bus.wr_word = 1'b0;
        check("word_byp_lo", 32'(bus.rd_data), 32'h34);
        check("word_byp_hi", 32'(bus.rd_data_h), 32'h12);
        check("word_byp_rr", 32'(bus.rr_data), 32'h12);
        bus.rr_addr = 5'd7;
        tick();
        check("word_rd_lo", 32'(bus.rd_data), 32'h34);
        check("word_rd_hi", 32'(bus.rd_data_h), 32'h12);
        check("r7_kept", 32'(bus.rr_data), 32'h5C);

        // Z pointer: word write r30/r31 then byte write r31
        bus.rd_addr = 5'd30;
        tick();
        bus.wr = 1'b1;
        bus.wr_word = 1'b1;
        bus.data_in = 8'hEF;
        bus.data_in_h = 8'hBE;
        bus.rd_addr = 5'd31;
        tick();
        check("z_word", 32'(bus.z), 32'hBEEF);
        bus.wr_word = 1'b0;
        bus.data_in = 8'h00;
        bus.rd_addr = 5'd30;
        tick();
        bus.wr = 1'b0;
        check("z_byte", 32'(bus.z), 32'h00EF);
        check("r30_kept", 32'(bus.rd_data), 32'hEF);
        check("r31_byp", 32'(bus.rd_data_h), 32'h00);

        // Async reset clears outputs without waiting for an edge
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd1);
        check("arst_rd", 32'(bus.rd_data), 32'h00);
        check("arst_z", 32'(bus.z), 32'h0000);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd1);
        tick();
        rst_n = 1'b1;
        // Writes attempted throughout the restarted clear must be ignored
        bus.wr = 1'b1;
        bus.wr_word = 1'b1;
        bus.data_in = 8'hFF;
        bus.data_in_h = 8'hFF;
        bus.rd_addr = 5'd30;
        for (int i = 0; i < 32; i++) begin
            check("reclr_busy", 32'(bus.busy), 32'd1);
            check("reclr_rd", 32'(bus.rd_data), 32'h00);
            tick();
        end
        bus.wr = 1'b0;
        bus.wr_word = 1'b0;
        check("reclr_done", 32'(bus.busy), 32'd0);
        check("reclr_z", 32'(bus.z), 32'h0000);

        bus.rd_addr = 5'd3;
        bus.rr_addr = 5'd7;
        tick();
        check("cleared_r3", 32'(bus.rd_data), 32'h00);
        check("cleared_r7", 32'(bus.rr_data), 32'h00);
        bus.rd_addr = 5'd28;
        bus.rr_addr = 5'd30;
        tick();
        check("cleared_r28", 32'(bus.rd_data), 32'h00);
        check("cleared_r29", 32'(bus.rd_data_h), 32'h00);
        check("cleared_r30", 32'(bus.rr_data), 32'h00);
        check("cleared_z", 32'(bus.z), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
